// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX/MEM elastic pipeline register.
package ex_mem_pkg;

    localparam int EX_MEM_DATA_W = 32;
    localparam int EX_MEM_REG_AW = 5;

    typedef struct packed {
        logic                     RegWrite;
        logic                     MemtoReg;
        logic                     MemWrite;
        logic                     MemRead;
        logic [EX_MEM_REG_AW-1:0] WriteReg;
        logic [EX_MEM_DATA_W-1:0] AluResult;
        logic [EX_MEM_DATA_W-1:0] WriteData;
    } ex_mem_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ex_mem_state_t;

endpackage

// File: rtl/ex_mem_elastic_pipe_slot.sv
// One register slot with a valid bit; clear beats load, data holds on clear.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] dIn,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= dIn;
        end
    end

endmodule

// File: rtl/ex_mem_elastic.sv
// EX/MEM pipeline register with valid/ready handshake and an optional skid slot.
//   state | meaning
//   EMPTY | no bundle held
//   ONE   | output slot holds a bundle
//   FULL  | output and skid slots both hold bundles, EX is stalled
module ex_mem_elastic
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int REG_AW = EX_MEM_REG_AW,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [DATA_W-1:0] AluResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic              ReadyE,
    input  logic              FlushM,
    input  logic              ReadyM,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              MemReadM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic [DATA_W-1:0] AluOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic              FwdValidM,
    output logic [1:0]        Occupancy
);

    localparam int BW = 4 + REG_AW + 2 * DATA_W;

    logic [BW-1:0] bundleE;
    logic [BW-1:0] outDin;
    logic [BW-1:0] outData;
    logic [3:0]    ctrlQ;
    logic          outValid;
    logic          outLoad;
    logic          outClear;
    logic          accept;
    logic          drain;

    assign bundleE  = {RegWriteE, MemtoRegE, MemWriteE, MemReadE, WriteRegE, AluResultE, WriteDataE};
    assign accept   = ValidE & ReadyE & ~FlushM;
    assign drain    = outValid & ReadyM;
    assign outClear = FlushM | (drain & ~outLoad);

    pipe_slot #(.W(BW)) uOutSlot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (outLoad),
        .clear (outClear),
        .dIn   (outDin),
        .valid (outValid),
        .q     (outData)
    );

    generate
        if (SKID) begin : gSkid
            logic          skidValid;
            logic [BW-1:0] skidData;
            logic          skidLoad;
            logic          skidClear;
            logic          readyReg;
            logic [1:0]    occReg;
            ex_mem_state_t state;

            // A waiting skid entry always refills the output slot before EX can.
            assign outLoad   = (drain & skidValid) | (accept & (~outValid | drain));
            assign outDin    = skidValid ? skidData : bundleE;
            assign skidLoad  = accept & outValid & ~drain;
            assign skidClear = FlushM | (skidValid & drain);

            pipe_slot #(.W(BW)) uSkidSlot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skidLoad),
                .clear (skidClear),
                .dIn   (bundleE),
                .valid (skidValid),
                .q     (skidData)
            );

            always_ff @(posedge clk) begin
                if (!rst_n || FlushM) begin
                    state    <= EMPTY;
                    readyReg <= 1'b1;
                    occReg   <= 2'd0;
                end else begin
                    case (state)
                        EMPTY: if (accept) begin
                            state  <= ONE;
                            occReg <= 2'd1;
                        end
                        ONE: if (accept && !drain) begin
                            state    <= FULL;
                            readyReg <= 1'b0;
                            occReg   <= 2'd2;
                        end else if (drain && !accept) begin
                            state  <= EMPTY;
                            occReg <= 2'd0;
                        end
                        FULL: if (drain) begin
                            state    <= ONE;
                            readyReg <= 1'b1;
                            occReg   <= 2'd1;
                        end
                        default: begin
                            state    <= EMPTY;
                            readyReg <= 1'b1;
                            occReg   <= 2'd0;
                        end
                    endcase
                end
            end

            assign ReadyE    = readyReg;
            assign Occupancy = occReg;
        end else begin : gNoSkid
            assign outLoad   = accept;
            assign outDin    = bundleE;
            assign ReadyE    = ~outValid | ReadyM;
            assign Occupancy = {1'b0, outValid};
        end
    endgenerate

    // Control bits are masked when idle; data fields keep their last value.
    assign {ctrlQ, WriteRegM, AluOutM, WriteDataM} = outData;
    assign ValidM    = outValid;
    assign RegWriteM = outValid & ctrlQ[3];
    assign MemtoRegM = outValid & ctrlQ[2];
    assign MemWriteM = outValid & ctrlQ[1];
    assign MemReadM  = outValid & ctrlQ[0];
    assign FwdValidM = ValidM & RegWriteM & (WriteRegM != '0);

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Scoreboard bench for ex_mem_elastic: one skid build and one single-entry build.
module tb_ex_mem_elastic;
    import ex_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, ValidE0;
    logic        RegWriteE, MemtoRegE, MemWriteE, MemReadE;
    logic [4:0]  WriteRegE;
    logic [31:0] AluResultE, WriteDataE;
    logic        FlushM, FlushM0, ReadyM, ReadyM0;

    logic        ReadyE, ValidM, RegWriteM, MemtoRegM, MemWriteM, MemReadM, FwdValidM;
    logic [4:0]  WriteRegM;
    logic [31:0] AluOutM, WriteDataM;
    logic [1:0]  Occupancy;

    logic        ReadyE0, ValidM0, RegWriteM0, MemtoRegM0, MemWriteM0, MemReadM0, FwdValidM0;
    logic [4:0]  WriteRegM0;
    logic [31:0] AluOutM0, WriteDataM0;
    logic [1:0]  Occupancy0;

    int checks = 0;
    int errors = 0;

    ex_mem_bundle_t q1[$];
    ex_mem_bundle_t q0[$];

    always #5 clk = ~clk;

    ex_mem_elastic #(.DATA_W(32), .REG_AW(5), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .WriteRegE(WriteRegE), .AluResultE(AluResultE), .WriteDataE(WriteDataE),
        .ReadyE(ReadyE), .FlushM(FlushM), .ReadyM(ReadyM), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .WriteRegM(WriteRegM), .AluOutM(AluOutM), .WriteDataM(WriteDataM),
        .FwdValidM(FwdValidM), .Occupancy(Occupancy)
    );

    ex_mem_elastic #(.DATA_W(32), .REG_AW(5), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE0),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .WriteRegE(WriteRegE), .AluResultE(AluResultE), .WriteDataE(WriteDataE),
        .ReadyE(ReadyE0), .FlushM(FlushM0), .ReadyM(ReadyM0), .ValidM(ValidM0),
        .RegWriteM(RegWriteM0), .MemtoRegM(MemtoRegM0), .MemWriteM(MemWriteM0), .MemReadM(MemReadM0),
        .WriteRegM(WriteRegM0), .AluOutM(AluOutM0), .WriteDataM(WriteDataM0),
        .FwdValidM(FwdValidM0), .Occupancy(Occupancy0)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_bundle_t mk(input logic rw, input logic m2r, input logic mw, input logic mr,
                                          input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd);
        ex_mem_bundle_t b;
        b = {rw, m2r, mw, mr, wr, alu, wd};
        return b;
    endfunction

    task automatic drive(input ex_mem_bundle_t b);
        RegWriteE  = b.RegWrite;
        MemtoRegE  = b.MemtoReg;
        MemWriteE  = b.MemWrite;
        MemReadE   = b.MemRead;
        WriteRegE  = b.WriteReg;
        AluResultE = b.AluResult;
        WriteDataE = b.WriteData;
    endtask

    // Monitors: each drained bundle must match the head of its expected queue.
    always @(negedge clk) begin : mon1
        ex_mem_bundle_t act, exp;
        if (rst_n && ValidM && ReadyM) begin
            act = {RegWriteM, MemtoRegM, MemWriteM, MemReadM, WriteRegM, AluOutM, WriteDataM};
            if (q1.size() == 0) begin
                check("skid_unexpected_out", {23'd0, act}, 96'd0);
            end else begin
                exp = q1.pop_front();
                check("skid_out_bundle", {23'd0, act}, {23'd0, exp});
            end
        end
    end

    always @(negedge clk) begin : mon0
        ex_mem_bundle_t act, exp;
        if (rst_n && ValidM0 && ReadyM0) begin
            act = {RegWriteM0, MemtoRegM0, MemWriteM0, MemReadM0, WriteRegM0, AluOutM0, WriteDataM0};
            if (q0.size() == 0) begin
                check("noskid_unexpected_out", {23'd0, act}, 96'd0);
            end else begin
                exp = q0.pop_front();
                check("noskid_out_bundle", {23'd0, act}, {23'd0, exp});
            end
        end
    end

    initial begin
        ex_mem_bundle_t bA, bB, bC, bD, bE, bF, bG, bH, bI, bZ;
        ex_mem_bundle_t tp[4];
        ex_mem_bundle_t jb[3];
        bit rdyPat[5];
        bit expRdy[5];
        int k;

        rst_n = 1'b0; ValidE = 1'b0; ValidE0 = 1'b0; FlushM = 1'b0; FlushM0 = 1'b0;
        ReadyM = 1'b0; ReadyM0 = 1'b0;
        drive(mk(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        tick(); tick();
        check("rst_validm", ValidM, 0);
        check("rst_occ", Occupancy, 0);
        check("rst_readye", ReadyE, 1);
        check("rst_aluout", AluOutM, 0);
        check("rst_writereg", WriteRegM, 0);
        check("rst_regwrite", RegWriteM, 0);
        rst_n = 1'b1;
        tick();
        check("readye_after_rst", ReadyE, 1);

        // Single bundle, one-cycle latency.
        bA = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0000_AAAA);
        ReadyM = 1'b1; ValidE = 1'b1; drive(bA); q1.push_back(bA);
        tick();
        ValidE = 1'b0;
        check("t1_validm", ValidM, 1);
        check("t1_aluout", AluOutM, 32'h0000_1234);
        check("t1_fwdvalid", FwdValidM, 1);
        tick();
        check("t1_validm_drop", ValidM, 0);
        check("t1_regwrite_idle", RegWriteM, 0);
        check("t1_writereg_hold", WriteRegM, 5);
        check("t1_aluout_hold", AluOutM, 32'h0000_1234);

        // Stall fills the skid slot, then drains in order.
        bA = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'hA000_0001, 32'h0000_00A1);
        bB = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'hB000_0002, 32'h0000_00B2);
        bC = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hC000_0003, 32'h0000_00C3);
        q1.push_back(bA); q1.push_back(bB); q1.push_back(bC);
        ReadyM = 1'b0; ValidE = 1'b1; drive(bA);
        tick();
        drive(bB);
        tick();
        drive(bC);
        tick();
        check("t2_occ_full", Occupancy, 2);
        check("t2_readye_full", ReadyE, 0);
        check("t2_out_is_a", AluOutM, 32'hA000_0001);
        ReadyM = 1'b1;
        tick();
        check("t2_out_is_b", AluOutM, 32'hB000_0002);
        check("t2_readye_back", ReadyE, 1);
        tick();
        ValidE = 1'b0;
        check("t2_out_is_c", AluOutM, 32'hC000_0003);
        tick();
        check("t2_empty", ValidM, 0);

        // Flush while FULL with a new bundle arriving.
        bD = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'hD000_0004, 32'h0);
        bE = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'hE000_0005, 32'h0);
        bF = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hF000_0006, 32'h0);
        ReadyM = 1'b0; ValidE = 1'b1; drive(bD);
        tick();
        drive(bE);
        tick();
        check("t3_occ_full", Occupancy, 2);
        FlushM = 1'b1; drive(bF);
        tick();
        FlushM = 1'b0; ValidE = 1'b0;
        check("t3_validm", ValidM, 0);
        check("t3_occ", Occupancy, 0);
        check("t3_readye", ReadyE, 1);
        ReadyM = 1'b1;
        tick(); tick();
        check("t3_still_empty", ValidM, 0);

        // Write to r0 must not forward.
        bZ = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0055, 32'h0000_0066);
        ValidE = 1'b1; drive(bZ); q1.push_back(bZ);
        tick();
        ValidE = 1'b0;
        check("t4_validm", ValidM, 1);
        check("t4_fwd_r0", FwdValidM, 0);
        tick();

        // Full throughput with ReadyM high.
        tp[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h1111_0000, 32'h1);
        tp[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h2222_0000, 32'h2);
        tp[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h3333_0000, 32'h3);
        tp[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'h4444_0000, 32'h4);
        ValidE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(tp[i]); q1.push_back(tp[i]);
            tick();
            check("tp_validm", ValidM, 1);
            check("tp_aluout", AluOutM, tp[i].AluResult);
            check("tp_occ", Occupancy, 1);
        end
        ValidE = 1'b0;
        tick();
        check("tp_drained", ValidM, 0);

        // Reset while FULL, then one-cycle latency afterwards.
        bG = mk(1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 32'h6666_0000, 32'h6);
        bH = mk(1'b1, 1'b1, 1'b1, 1'b1, 5'd21, 32'h7777_0000, 32'h7);
        bI = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd22, 32'h8888_0000, 32'h8);
        ReadyM = 1'b0; ValidE = 1'b1; drive(bG);
        tick();
        drive(bH);
        tick();
        ValidE = 1'b0;
        check("t5_occ_full", Occupancy, 2);
        rst_n = 1'b0;
        tick();
        check("t5_validm", ValidM, 0);
        check("t5_occ", Occupancy, 0);
        check("t5_readye", ReadyE, 1);
        check("t5_ctrl", {RegWriteM, MemtoRegM, MemWriteM, MemReadM}, 0);
        check("t5_data", {WriteRegM, AluOutM, WriteDataM}, 0);
        rst_n = 1'b1; ReadyM = 1'b1; ValidE = 1'b1; drive(bI); q1.push_back(bI);
        tick();
        ValidE = 1'b0;
        check("t5_post_validm", ValidM, 1);
        check("t5_post_aluout", AluOutM, 32'h8888_0000);
        tick();

        // Single-entry build: combinational ReadyE under a toggling ReadyM.
        jb[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0A0A_0001, 32'h11);
        jb[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0B0B_0002, 32'h22);
        jb[2] = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0C0C_0003, 32'h33);
        for (int i = 0; i < 3; i++) q0.push_back(jb[i]);
        rdyPat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        expRdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        k = 0;
        ValidE0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ReadyM0 = rdyPat[i];
            drive(jb[k]);
            #1;
            check("s0_readye", ReadyE0, expRdy[i]);
            if (i == 1) begin
                ReadyM0 = 1'b1;
                #1;
                check("s0_readye_same_cycle", ReadyE0, 1);
                ReadyM0 = 1'b0;
                #1;
            end
            tick();
            if (expRdy[i]) k++;
        end
        ValidE0 = 1'b0; ReadyM0 = 1'b1;
        tick();
        check("s0_last_out", AluOutM0, 32'h0C0C_0003);
        tick();
        check("s0_empty", ValidM0, 0);

        check("skid_queue_empty", q1.size(), 0);
        check("noskid_queue_empty", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
